i2cmb_wb_seq: RTL and testbench
===============================

I2CMB_WB_SEQ -- requirements
Module: i2cmb_wb_seq

Interface
REQ-001 SHALL have parameter WB_ADDR_WIDTH, default 2, Wishbone address width.
REQ-002 SHALL have parameter WB_DATA_WIDTH, default 8, Wishbone data width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 65535, maximum clk_i cycles to wait for irq_i per command.
REQ-004 SHALL have ports: clk_i  in  1  clock, single clock domain.
REQ-005 SHALL have ports: rst_i  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports: req_valid_i  in  1 / req_ready_o  out  1  request handshake.
REQ-007 SHALL have ports: req_bus_i  in  4  bus id; req_addr_i  in  7  I2C slave address; req_rw_i  in  1  (1 = read); req_data_i  in  8  write byte.
REQ-008 SHALL have ports: rsp_valid_o  out  1  one-cycle response strobe; rsp_data_o  out  8  read byte; rsp_status_o  out  3  (0 OK, 1 NAK, 2 ARB_LOST, 3 ERR, 4 TIMEOUT).
REQ-009 SHALL have ports: cyc_o, stb_o, we_o  out  1 each; adr_o  out  WB_ADDR_WIDTH; dat_o  out  WB_DATA_WIDTH; dat_i  in  WB_DATA_WIDTH; ack_i  in  1; irq_i  in  1; these are Wishbone master signals driving the IICMB core.

Function
REQ-010 SHALL use the IICMB register map: adr 0 CSR, 1 DPR, 2 CMDR, 3 FSMR; CMDR commands: WAIT=000, WRITE=001, READ_ACK=010, READ_NAK=011, START=100, STOP=101, SET_BUS=110; CMDR status bits: 7 DON, 6 NAK, 5 AL, 4 ERR.
REQ-011 SHALL perform each Wishbone access by asserting cyc_o, stb_o, we_o, adr_o, dat_o together and holding them stable until the cycle ack_i=1 is sampled, then deassert cyc_o/stb_o for at least one cycle.
REQ-012 SHALL capture dat_i on the ack_i cycle of a read access.
REQ-013 SHALL, after reset release, write CSR=0xC0 (enable, IE) before asserting req_ready_o.
REQ-014 SHALL assert req_ready_o only in IDLE; a request is accepted on the cycle where req_valid_i and req_ready_o are both 1, and req_* fields are registered then.
REQ-015 SHALL execute per request: DPR<=bus, CMDR<=SET_BUS, WAIT_DONE; CMDR<=START, WAIT_DONE; DPR<={addr,rw}, CMDR<=WRITE, WAIT_DONE; write: DPR<=data, CMDR<=WRITE, WAIT_DONE; read: CMDR<=READ_NAK, WAIT_DONE, read DPR into rsp_data_o; CMDR<=STOP, WAIT_DONE; respond.
REQ-016 SHALL implement WAIT_DONE as: wait for irq_i=1, then read CMDR (clearing irq), then decode status with priority AL > ERR > NAK > DON.
REQ-017 SHALL, on NAK in an address or data byte, issue STOP, then respond NAK; read data SHALL be 0x00.
REQ-018 SHALL, on AL or ERR, skip STOP and respond ARB_LOST or ERR immediately.
REQ-019 SHALL count clk_i cycles while waiting for irq_i; on reaching TIMEOUT_CYCLES it SHALL abandon the request, write CSR=0x00 then CSR=0xC0 (core reset), and respond TIMEOUT.
REQ-020 SHALL pulse rsp_valid_o for exactly one cycle per accepted request; rsp_data_o and rsp_status_o SHALL hold until the next response.
REQ-021 SHALL ignore irq_i outside WAIT_DONE, and a stale irq_i in IDLE SHALL NOT alter state.
REQ-022 SHALL keep states: INIT, IDLE, WB_XFER, WAIT_IRQ, READ_STATUS, DECODE, RESP, and a per-request step counter (0..6) selecting the next register access.
REQ-023 SHALL ignore req_valid_i while not in IDLE; no queueing.

Reset
REQ-024 SHALL, while rst_i=0, force cyc_o=stb_o=we_o=0, adr_o=0, dat_o=0, req_ready_o=0, rsp_valid_o=0, rsp_data_o=0x00, rsp_status_o=0, timeout counter 0, state INIT.
REQ-025 SHALL, on rst_i asserted mid-operation (including mid Wishbone cycle), drop cyc_o/stb_o asynchronously, emit no response, and restart from INIT after release.

Verification
REQ-026 Reset release -> first access is write adr 0 dat 0xC0; req_ready_o=1 only after its ack.
REQ-027 Write req bus 0, addr 0x22, data 0x5A, slave ACKs -> DPR writes 0x00, 0x44, 0x5A in order; STOP issued; rsp_status_o=0.
REQ-028 Read req addr 0x22, slave returns 0xA5 -> DPR write 0x45, CMDR 011, rsp_data_o=0xA5, status 0.
REQ-029 Address NAK (no slave) -> STOP issued, rsp_status_o=1, rsp_data_o=0x00, no data byte written.
REQ-030 Hold irq_i low with TIMEOUT_CYCLES=100 -> after 100 cycles CSR writes 0x00 then 0xC0, rsp_status_o=4.
REQ-031 Assert rst_i=0 while stb_o=1 awaiting ack -> cyc_o/stb_o low same cycle, no rsp_valid_o, INIT sequence repeats after release.

Source files
------------

// File: rtl/i2cmb_wb_seq.sv
// Purpose: sequences one I2C byte transfer (set bus, start, address, data, stop) through an IICMB core over Wishbone.
// Latency: per request, about 13 Wishbone accesses plus the core's irq delays; a stuck core gives up after TIMEOUT_CYCLES.
// Backpressure: req_ready_o is high only in IDLE, so requests stall while one is in flight; responses are a one-cycle strobe that cannot be stalled.
module i2cmb_wb_seq #(
  parameter int WB_ADDR_WIDTH  = 2,
  parameter int WB_DATA_WIDTH  = 8,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [3:0]               req_bus_i,
  input  logic [6:0]               req_addr_i,
  input  logic                     req_rw_i,
  input  logic [7:0]               req_data_i,
  output logic                     rsp_valid_o,
  output logic [7:0]               rsp_data_o,
  output logic [2:0]               rsp_status_o,
  output logic                     cyc_o,
  output logic                     stb_o,
  output logic                     we_o,
  output logic [WB_ADDR_WIDTH-1:0] adr_o,
  output logic [WB_DATA_WIDTH-1:0] dat_o,
  input  logic [WB_DATA_WIDTH-1:0] dat_i,
  input  logic                     ack_i,
  input  logic                     irq_i
);

  // Controller states
  localparam logic [2:0] S_INIT        = 3'd0;
  localparam logic [2:0] S_IDLE        = 3'd1;
  localparam logic [2:0] S_WB_XFER     = 3'd2;
  localparam logic [2:0] S_WAIT_IRQ    = 3'd3;
  localparam logic [2:0] S_READ_STATUS = 3'd4;
  localparam logic [2:0] S_DECODE      = 3'd5;
  localparam logic [2:0] S_RESP        = 3'd6;

  // Which register access WB_XFER performs
  localparam logic [2:0] OP_DPR_W   = 3'd0;
  localparam logic [2:0] OP_CMD_W   = 3'd1;
  localparam logic [2:0] OP_DPR_R   = 3'd2;
  localparam logic [2:0] OP_CSR_OFF = 3'd3;
  localparam logic [2:0] OP_CSR_ON  = 3'd4;

  // Request steps
  localparam logic [2:0] ST_BUS   = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_ADDR  = 3'd2;
  localparam logic [2:0] ST_DATA  = 3'd3;
  localparam logic [2:0] ST_RDDPR = 3'd4;
  localparam logic [2:0] ST_STOP  = 3'd5;

  // Response codes
  localparam logic [2:0] RS_OK  = 3'd0;
  localparam logic [2:0] RS_NAK = 3'd1;
  localparam logic [2:0] RS_AL  = 3'd2;
  localparam logic [2:0] RS_ERR = 3'd3;
  localparam logic [2:0] RS_TMO = 3'd4;

  localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

  // Steps that load DPR before their command start with a DPR write; the read-back step is a DPR read.
  function automatic logic [2:0] first_op(input logic [2:0] s, input logic rw);
    if (s == ST_BUS || s == ST_ADDR || (s == ST_DATA && !rw)) return OP_DPR_W;
    else if (s == ST_RDDPR) return OP_DPR_R;
    else return OP_CMD_W;
  endfunction

  logic [2:0]               state_q, state_d;
  logic [2:0]               op_q, op_d;
  logic [2:0]               step_q, step_d;
  logic [3:0]               bus_q, bus_d;
  logic [6:0]               addr_q, addr_d;
  logic                     rw_q, rw_d;
  logic [7:0]               wdata_q, wdata_d;
  logic [7:0]               rd_data_q, rd_data_d;
  logic [2:0]               stat_q, stat_d;
  logic [3:0]               cmdr_q, cmdr_d;     // DON, NAK, AL, ERR
  logic [TW-1:0]            tmo_q, tmo_d;
  logic                     cyc_q, cyc_d;
  logic                     we_q, we_d;
  logic [WB_ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [WB_DATA_WIDTH-1:0] dat_q, dat_d;
  logic                     rsp_valid_q, rsp_valid_d;
  logic [7:0]               rsp_data_q, rsp_data_d;
  logic [2:0]               rsp_status_q, rsp_status_d;

  logic                     acc_we;
  logic [1:0]               acc_adr;
  logic [7:0]               acc_dat;
  logic [2:0]               cmd_code;
  logic [2:0]               nstep;
  logic                     wb_done;

  // Decode the access that the current state/op/step should put on the bus
  always_comb begin
    acc_we  = 1'b1;
    acc_adr = 2'd0;
    acc_dat = 8'h00;
    case (step_q)
      ST_BUS:   cmd_code = 3'b110;
      ST_START: cmd_code = 3'b100;
      ST_ADDR:  cmd_code = 3'b001;
      ST_DATA:  cmd_code = rw_q ? 3'b011 : 3'b001;
      default:  cmd_code = 3'b101;
    endcase
    if (state_q == S_INIT) begin
      acc_dat = 8'hC0;
    end else if (state_q == S_READ_STATUS) begin
      acc_we  = 1'b0;
      acc_adr = 2'd2;
    end else begin
      case (op_q)
        OP_DPR_W: begin
          acc_adr = 2'd1;
          if (step_q == ST_BUS)       acc_dat = {4'h0, bus_q};
          else if (step_q == ST_ADDR) acc_dat = {addr_q, rw_q};
          else                        acc_dat = wdata_q;
        end
        OP_CMD_W: begin
          acc_adr = 2'd2;
          acc_dat = {5'b00000, cmd_code};
        end
        OP_DPR_R: begin
          acc_we  = 1'b0;
          acc_adr = 2'd1;
        end
        OP_CSR_OFF: acc_dat = 8'h00;
        default:    acc_dat = 8'hC0;
      endcase
    end
  end

  // Main sequencer: launch/complete Wishbone accesses and walk the request steps
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    step_d       = step_q;
    bus_d        = bus_q;
    addr_d       = addr_q;
    rw_d         = rw_q;
    wdata_d      = wdata_q;
    rd_data_d    = rd_data_q;
    stat_d       = stat_q;
    cmdr_d       = cmdr_q;
    tmo_d        = tmo_q;
    cyc_d        = cyc_q;
    we_d         = we_q;
    adr_d        = adr_q;
    dat_d        = dat_q;
    rsp_valid_d  = 1'b0;
    rsp_data_d   = rsp_data_q;
    rsp_status_d = rsp_status_q;
    nstep        = step_q + 3'd1;
    wb_done      = cyc_q & ack_i;

    // Bus-owning states: raise the access when idle, drop it for a cycle once acked
    if (state_q == S_INIT || state_q == S_WB_XFER || state_q == S_READ_STATUS) begin
      if (!cyc_q) begin
        cyc_d = 1'b1;
        we_d  = acc_we;
        adr_d = WB_ADDR_WIDTH'(acc_adr);
        dat_d = WB_DATA_WIDTH'(acc_dat);
      end else if (ack_i) begin
        cyc_d = 1'b0;
      end
    end

    case (state_q)
      S_INIT: begin
        if (wb_done) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (req_valid_i) begin
          bus_d     = req_bus_i;
          addr_d    = req_addr_i;
          rw_d      = req_rw_i;
          wdata_d   = req_data_i;
          step_d    = ST_BUS;
          op_d      = OP_DPR_W;
          stat_d    = RS_OK;
          rd_data_d = 8'h00;
          state_d   = S_WB_XFER;
        end
      end
      S_WB_XFER: begin
        if (wb_done) begin
          case (op_q)
            OP_DPR_W: op_d = OP_CMD_W;
            OP_CMD_W: begin
              tmo_d   = '0;
              state_d = S_WAIT_IRQ;
            end
            OP_DPR_R: begin
              rd_data_d = dat_i[7:0];
              step_d    = ST_STOP;
              op_d      = OP_CMD_W;
            end
            OP_CSR_OFF: op_d = OP_CSR_ON;
            default:    state_d = S_RESP;
          endcase
        end
      end
      S_WAIT_IRQ: begin
        if (irq_i) begin
          state_d = S_READ_STATUS;
        end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          // Core is stuck: bounce its enable to reset it, then report
          stat_d    = RS_TMO;
          rd_data_d = 8'h00;
          op_d      = OP_CSR_OFF;
          state_d   = S_WB_XFER;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_READ_STATUS: begin
        if (wb_done) begin
          cmdr_d  = dat_i[7:4];
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (cmdr_q[1]) begin
          stat_d  = RS_AL;
          state_d = S_RESP;
        end else if (cmdr_q[0]) begin
          stat_d  = RS_ERR;
          state_d = S_RESP;
        end else if (cmdr_q[2] && (step_q == ST_ADDR || step_q == ST_DATA)) begin
          // Slave refused a byte: still release the bus with STOP
          stat_d    = RS_NAK;
          rd_data_d = 8'h00;
          step_d    = ST_STOP;
          op_d      = OP_CMD_W;
          state_d   = S_WB_XFER;
        end else if (cmdr_q[3] || cmdr_q[2]) begin
          if (step_q == ST_STOP) begin
            state_d = S_RESP;
          end else begin
            if (step_q == ST_DATA && !rw_q) nstep = ST_STOP;
            step_d  = nstep;
            op_d    = first_op(nstep, rw_q);
            state_d = S_WB_XFER;
          end
        end else begin
          // irq without any status bit: treat as a core error
          stat_d  = RS_ERR;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        rsp_valid_d  = 1'b1;
        rsp_data_d   = rd_data_q;
        rsp_status_d = stat_q;
        state_d      = S_IDLE;
      end
      default: state_d = S_INIT;
    endcase
  end

  // State registers; reset drops the bus cycle immediately and restarts at INIT
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= S_INIT;
      op_q         <= OP_DPR_W;
      step_q       <= ST_BUS;
      bus_q        <= '0;
      addr_q       <= '0;
      rw_q         <= 1'b0;
      wdata_q      <= '0;
      rd_data_q    <= '0;
      stat_q       <= RS_OK;
      cmdr_q       <= '0;
      tmo_q        <= '0;
      cyc_q        <= 1'b0;
      we_q         <= 1'b0;
      adr_q        <= '0;
      dat_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_status_q <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      step_q       <= step_d;
      bus_q        <= bus_d;
      addr_q       <= addr_d;
      rw_q         <= rw_d;
      wdata_q      <= wdata_d;
      rd_data_q    <= rd_data_d;
      stat_q       <= stat_d;
      cmdr_q       <= cmdr_d;
      tmo_q        <= tmo_d;
      cyc_q        <= cyc_d;
      we_q         <= we_d;
      adr_q        <= adr_d;
      dat_q        <= dat_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_status_q <= rsp_status_d;
    end
  end

  assign req_ready_o  = (state_q == S_IDLE);
  assign cyc_o        = cyc_q;
  assign stb_o        = cyc_q;
  assign we_o         = we_q;
  assign adr_o        = adr_q;
  assign dat_o        = dat_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_data_o   = rsp_data_q;
  assign rsp_status_o = rsp_status_q;

endmodule

// File: tb/tb_i2cmb_wb_seq.sv
// Directed bench for i2cmb_wb_seq against a small behavioural IICMB register model.
// The model logs every acked access; expected access lists are built by hand per scenario.
module tb_i2cmb_wb_seq;
  localparam int TMO = 100;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       req_valid_i, req_ready_o, req_rw_i;
  logic [3:0] req_bus_i;
  logic [6:0] req_addr_i;
  logic [7:0] req_data_i, rsp_data_o, dat_o, dat_i;
  logic       rsp_valid_o, cyc_o, stb_o, we_o, ack_i, irq_i;
  logic [2:0] rsp_status_o;
  logic [1:0] adr_o;

  i2cmb_wb_seq #(.WB_ADDR_WIDTH(2), .WB_DATA_WIDTH(8), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_bus_i(req_bus_i), .req_addr_i(req_addr_i), .req_rw_i(req_rw_i), .req_data_i(req_data_i),
    .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o), .rsp_status_o(rsp_status_o),
    .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o), .dat_o(dat_o),
    .dat_i(dat_i), .ack_i(ack_i), .irq_i(irq_i)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic int acc(input int we, input int adr, input int dat);
    return (we << 12) | (adr << 8) | dat;
  endfunction

  // ---------------- IICMB model ----------------
  int         log_q[$];
  int         start_cyc[$];
  int         ack_cyc[$];
  logic [7:0] stat_fifo[$];
  int         exp_q[$];
  int         cyc_n = 0;
  int         wait_cnt = 0;
  int         irq_cnt = -1;
  bit         hold_ack = 0;
  bit         no_irq = 0;
  logic       irq_m = 1'b0;
  logic       stale_irq = 1'b0;
  logic [7:0] rd_byte = 8'h00;
  int         rsp_cnt = 0;
  logic [7:0] last_data;
  logic [2:0] last_stat;

  assign irq_i = irq_m | stale_irq;

  initial begin
    ack_i = 1'b0;
    dat_i = 8'h00;
  end

  always @(negedge clk_i) begin
    cyc_n++;
    if (!rst_i) begin
      ack_i = 1'b0;
      irq_m = 1'b0;
      irq_cnt = -1;
      wait_cnt = 0;
    end else begin
      if (irq_cnt > 0) irq_cnt--;
      else if (irq_cnt == 0) begin
        irq_m = 1'b1;
        irq_cnt = -1;
      end
      if (ack_i) begin
        ack_i = 1'b0;
        wait_cnt = 0;
      end else if (cyc_o && stb_o) begin
        if (wait_cnt == 0) start_cyc.push_back(cyc_n);
        if (!hold_ack && wait_cnt >= 1) begin
          ack_i = 1'b1;
          ack_cyc.push_back(cyc_n);
          if (we_o) begin
            log_q.push_back(acc(1, int'(adr_o), int'(dat_o)));
            if (adr_o == 2'd2 && !no_irq) irq_cnt = 3;
          end else begin
            log_q.push_back(acc(0, int'(adr_o), 0));
            if (adr_o == 2'd2) begin
              dat_i = (stat_fifo.size() > 0) ? stat_fifo.pop_front() : 8'h80;
              irq_m = 1'b0;
            end else begin
              dat_i = rd_byte;
            end
          end
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  always @(negedge clk_i) begin
    if (rsp_valid_o === 1'b1) begin
      rsp_cnt++;
      last_data = rsp_data_o;
      last_stat = rsp_status_o;
    end
  end

  // ---------------- helpers ----------------
  task automatic clear_log();
    log_q.delete();
    start_cyc.delete();
    ack_cyc.delete();
    exp_q.delete();
    stat_fifo.delete();
  endtask

  task automatic e(input int we, input int adr, input int dat);
    exp_q.push_back(acc(we, adr, dat));
  endtask

  task automatic exp_head(input int bus, input logic [6:0] addr, input logic rw);
    e(1, 1, bus); e(1, 2, 6); e(0, 2, 0);
    e(1, 2, 4); e(0, 2, 0);
    e(1, 1, int'({addr, rw})); e(1, 2, 1); e(0, 2, 0);
  endtask

  task automatic exp_stop();
    e(1, 2, 5); e(0, 2, 0);
  endtask

  task automatic check_log(input string tag);
    int n;
    chk({tag, "_nacc"}, log_q.size(), exp_q.size());
    n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s_acc%0d", tag, i), log_q[i], exp_q[i]);
  endtask

  task automatic wait_ready(input string tag);
    bit ok = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk_i);
      if (req_ready_o === 1'b1) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk({tag, "_ready_wait"}, {31'd0, ok}, 1);
  endtask

  task automatic send_req(input logic [3:0] bus, input logic [6:0] addr, input logic rw, input logic [7:0] data);
    wait_ready("req");
    req_bus_i = bus; req_addr_i = addr; req_rw_i = rw; req_data_i = data;
    req_valid_i = 1'b1;
    @(negedge clk_i);
    req_valid_i = 1'b0;
  endtask

  task automatic do_req(input string tag, input logic [3:0] bus, input logic [6:0] addr,
                        input logic rw, input logic [7:0] data);
    int  c0;
    bit  got = 0;
    c0 = rsp_cnt;
    send_req(bus, addr, rw, data);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk_i);
      if (rsp_cnt != c0) begin
        got = 1;
        break;
      end
    end
    repeat (3) @(negedge clk_i);
    chk({tag, "_rsp_once"}, rsp_cnt - c0, got ? 1 : 32'hFFFF_FFFF);
  endtask

  // ---------------- scenarios ----------------
  initial begin
    int  d;
    int  c0;
    bit  seen;
    rst_i = 1'b0;
    req_valid_i = 1'b0; req_bus_i = '0; req_addr_i = '0; req_rw_i = 1'b0; req_data_i = '0;
    repeat (3) @(negedge clk_i);
    chk("rst_wb",  {20'd0, cyc_o, stb_o, we_o, adr_o, dat_o}, 0);
    chk("rst_rdy", {31'd0, req_ready_o}, 0);
    chk("rst_rsp", {20'd0, rsp_valid_o, rsp_data_o, rsp_status_o}, 0);

    // Init: CSR <= C0 before ready
    clear_log();
    rst_i = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (cyc_o === 1'b1) begin
        seen = 1;
        break;
      end
    end
    chk("init_cyc_seen", {31'd0, seen}, 1);
    chk("init_rdy_low", {31'd0, req_ready_o}, 0);
    chk("init_access", {21'd0, we_o, adr_o, dat_o}, {21'd0, 1'b1, 2'd0, 8'hC0});
    wait_ready("init");
    e(1, 0, 8'hC0);
    check_log("init");

    // Stale irq while idle must not start anything
    clear_log();
    c0 = rsp_cnt;
    stale_irq = 1'b1;
    repeat (10) @(negedge clk_i);
    chk("stale_rdy", {31'd0, req_ready_o}, 1);
    chk("stale_nacc", log_q.size(), 0);
    chk("stale_rsp", rsp_cnt - c0, 0);
    stale_irq = 1'b0;
    repeat (2) @(negedge clk_i);

    // Write bus 0, addr 0x22, data 0x5A
    clear_log();
    rd_byte = 8'h99;
    do_req("wr", 4'd0, 7'h22, 1'b0, 8'h5A);
    exp_head(0, 7'h22, 1'b0); e(1, 1, 8'h5A); e(1, 2, 1); e(0, 2, 0); exp_stop();
    check_log("wr");
    chk("wr_stat", last_stat, 0);
    chk("wr_data", last_data, 0);

    // Read addr 0x22, slave returns 0xA5
    clear_log();
    rd_byte = 8'hA5;
    do_req("rd", 4'd0, 7'h22, 1'b1, 8'h00);
    exp_head(0, 7'h22, 1'b1); e(1, 2, 3); e(0, 2, 0); e(0, 1, 0); exp_stop();
    check_log("rd");
    chk("rd_stat", last_stat, 0);
    chk("rd_data", last_data, 8'hA5);

    // Address NAK on a read: STOP, status 1, data forced to 0
    clear_log();
    stat_fifo.push_back(8'h80); stat_fifo.push_back(8'h80); stat_fifo.push_back(8'hC0);
    do_req("nak", 4'd3, 7'h22, 1'b1, 8'h00);
    exp_head(3, 7'h22, 1'b1); exp_stop();
    check_log("nak");
    chk("nak_stat", last_stat, 1);
    chk("nak_data", last_data, 0);

    // Arbitration lost at START: no STOP
    clear_log();
    stat_fifo.push_back(8'h80); stat_fifo.push_back(8'hA0);
    do_req("al", 4'd5, 7'h10, 1'b0, 8'h77);
    e(1, 1, 5); e(1, 2, 6); e(0, 2, 0); e(1, 2, 4); e(0, 2, 0);
    check_log("al");
    chk("al_stat", last_stat, 2);

    // ERR outranks NAK on the address byte: no STOP
    clear_log();
    stat_fifo.push_back(8'h80); stat_fifo.push_back(8'h80); stat_fifo.push_back(8'hD0);
    do_req("err", 4'd2, 7'h31, 1'b0, 8'h11);
    exp_head(2, 7'h31, 1'b0);
    check_log("err");
    chk("err_stat", last_stat, 3);

    // Timeout: irq never comes, core reset via CSR 00 then C0
    clear_log();
    no_irq = 1;
    do_req("tmo", 4'd1, 7'h22, 1'b0, 8'h5A);
    no_irq = 0;
    e(1, 1, 1); e(1, 2, 6); e(1, 0, 0); e(1, 0, 8'hC0);
    check_log("tmo");
    chk("tmo_stat", last_stat, 4);
    chk("tmo_data", last_data, 0);
    d = (start_cyc.size() > 2 && ack_cyc.size() > 1) ? (start_cyc[2] - ack_cyc[1]) : -1;
    chk("tmo_delay_in_range", {31'd0, (d >= TMO && d <= TMO + 2)}, 1);

    // Recovery after timeout
    clear_log();
    do_req("wr2", 4'd1, 7'h50, 1'b0, 8'h3C);
    exp_head(1, 7'h50, 1'b0); e(1, 1, 8'h3C); e(1, 2, 1); e(0, 2, 0); exp_stop();
    check_log("wr2");
    chk("wr2_stat", last_stat, 0);

    // Reset while a Wishbone access waits for ack
    clear_log();
    hold_ack = 1;
    c0 = rsp_cnt;
    send_req(4'd4, 7'h22, 1'b0, 8'h5A);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (cyc_o === 1'b1 && stb_o === 1'b1) begin
        seen = 1;
        break;
      end
      @(negedge clk_i);
    end
    chk("mid_stb_seen", {31'd0, seen}, 1);
    #2 rst_i = 1'b0;
    #1;
    chk("mid_rst_cyc_stb", {30'd0, cyc_o, stb_o}, 0);
    chk("mid_rst_rsp", {20'd0, rsp_valid_o, rsp_data_o, rsp_status_o}, 0);
    repeat (3) @(negedge clk_i);
    hold_ack = 0;
    clear_log();
    rst_i = 1'b1;
    wait_ready("mid");
    e(1, 0, 8'hC0);
    check_log("mid_init");
    repeat (3) @(negedge clk_i);
    chk("mid_no_rsp", rsp_cnt - c0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
